// File: rtl/cineraria_core_systimer_host.sv
// cineraria_core_systimer_host
// Avalon-MM initiator for a 16-bit interval-timer responder. It programs the
// 32-bit period, starts the timer, services every timeout by clearing the
// status register and counting ticks, and snapshots the live counter on demand.
// Every bus access lasts one cycle: the responder has no waitrequest.

module cineraria_core_systimer_host #(
  parameter bit CONTINUOUS = 1'b1,
  parameter bit IRQ_ENABLE = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] cfg_period,
  input  logic        cmd_start,
  input  logic        cmd_stop,
  input  logic        cmd_snap,
  output logic        busy,
  output logic        running,
  output logic        tick_pulse,
  output logic [31:0] tick_count,
  output logic        snap_valid,
  output logic [31:0] snap_value,
  output logic [2:0]  tmr_address,
  output logic        tmr_chipselect,
  output logic        tmr_write_n,
  output logic [15:0] tmr_writedata,
  input  logic [15:0] tmr_readdata,
  input  logic        tmr_irq
);

  typedef enum logic [3:0] {
    IDLE,
    WR_PL,
    WR_PH,
    GAP,
    WR_START,
    RUN,
    WR_CLR,
    CLR_WAIT,
    WR_SNAP,
    RD_SNL,
    RD_SNH,
    CAP_H,
    WR_STOP
  } state_t;

  // Timer register addresses
  localparam logic [2:0] ADDR_STATUS  = 3'd0;
  localparam logic [2:0] ADDR_CONTROL = 3'd1;
  localparam logic [2:0] ADDR_PERL    = 3'd2;
  localparam logic [2:0] ADDR_PERH    = 3'd3;
  localparam logic [2:0] ADDR_SNAPL   = 3'd4;
  localparam logic [2:0] ADDR_SNAPH   = 3'd5;

  // Control word that starts the timer: {STOP, START, CONT, ITO}
  localparam logic [15:0] CTRL_START = {12'b0, 1'b0, 1'b1, CONTINUOUS, IRQ_ENABLE};
  localparam logic [15:0] CTRL_STOP  = 16'h0008;

  state_t      state;
  state_t      state_next;
  logic        stop_pend;
  logic        snap_pend;
  logic        stop_req;
  logic        snap_req;
  logic [15:0] period_hi;
  logic [15:0] snap_lo;

  logic        bus_cs;
  logic        bus_write_n;
  logic [2:0]  bus_address;
  logic [15:0] bus_writedata;

  // A command arriving this cycle counts as pending so it is serviced at once
  assign stop_req = stop_pend | cmd_stop;
  assign snap_req = snap_pend | cmd_snap;

  assign busy = (state != IDLE) && (state != RUN);

  // Next-state selection; in RUN a timeout always outranks stop and snapshot
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (cmd_start) begin
          state_next = WR_PL;
        end else if (snap_req) begin
          state_next = WR_SNAP;
        end
      end
      WR_PL:    state_next = WR_PH;
      WR_PH:    state_next = GAP;
      GAP:      state_next = WR_START;
      WR_START: state_next = RUN;
      RUN: begin
        if (tmr_irq) begin
          state_next = WR_CLR;
        end else if (stop_req) begin
          state_next = WR_STOP;
        end else if (snap_req) begin
          state_next = WR_SNAP;
        end
      end
      WR_CLR:   state_next = CLR_WAIT;
      CLR_WAIT: state_next = CONTINUOUS ? RUN : IDLE;
      WR_SNAP:  state_next = RD_SNL;
      RD_SNL:   state_next = RD_SNH;
      RD_SNH:   state_next = CAP_H;
      CAP_H:    state_next = running ? RUN : IDLE;
      WR_STOP:  state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // Bus cycle for the state about to be entered, so the registered strobes line up with it
  always_comb begin
    bus_cs        = 1'b0;
    bus_write_n   = 1'b1;
    bus_address   = ADDR_STATUS;
    bus_writedata = 16'h0000;
    case (state_next)
      WR_PL: begin
        bus_cs        = 1'b1;
        bus_write_n   = 1'b0;
        bus_address   = ADDR_PERL;
        bus_writedata = cfg_period[15:0];
      end
      WR_PH: begin
        bus_cs        = 1'b1;
        bus_write_n   = 1'b0;
        bus_address   = ADDR_PERH;
        bus_writedata = period_hi;
      end
      WR_START: begin
        bus_cs        = 1'b1;
        bus_write_n   = 1'b0;
        bus_address   = ADDR_CONTROL;
        bus_writedata = CTRL_START;
      end
      WR_CLR: begin
        bus_cs        = 1'b1;
        bus_write_n   = 1'b0;
        bus_address   = ADDR_STATUS;
      end
      WR_SNAP: begin
        bus_cs        = 1'b1;
        bus_write_n   = 1'b0;
        bus_address   = ADDR_SNAPL;
      end
      RD_SNL: begin
        bus_cs        = 1'b1;
        bus_address   = ADDR_SNAPL;
      end
      RD_SNH: begin
        bus_cs        = 1'b1;
        bus_address   = ADDR_SNAPH;
      end
      WR_STOP: begin
        bus_cs        = 1'b1;
        bus_write_n   = 1'b0;
        bus_address   = ADDR_CONTROL;
        bus_writedata = CTRL_STOP;
      end
      default: begin
        bus_cs        = 1'b0;
      end
    endcase
  end

  // State register and registered bus outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      tmr_chipselect <= 1'b0;
      tmr_write_n    <= 1'b1;
      tmr_address    <= 3'd0;
      tmr_writedata  <= 16'h0000;
    end else begin
      state          <= state_next;
      tmr_chipselect <= bus_cs;
      tmr_write_n    <= bus_write_n;
      tmr_address    <= bus_address;
      tmr_writedata  <= bus_writedata;
    end
  end

  // Sticky stop/snap requests; each clears when its sequence is issued, and a stop in IDLE is dropped
  always_ff @(posedge clk) begin
    if (reset) begin
      stop_pend <= 1'b0;
      snap_pend <= 1'b0;
    end else begin
      if (state == IDLE) begin
        stop_pend <= 1'b0;
      end else if (state == RUN && state_next == WR_STOP) begin
        stop_pend <= 1'b0;
      end else if (cmd_stop) begin
        stop_pend <= 1'b1;
      end
      if (state_next == WR_SNAP && state != WR_SNAP) begin
        snap_pend <= 1'b0;
      end else if (cmd_snap) begin
        snap_pend <= 1'b1;
      end
    end
  end

  // Upper period half is held from the accepted start until the WR_PH write
  always_ff @(posedge clk) begin
    if (reset) begin
      period_hi <= 16'h0000;
    end else if (state == IDLE && cmd_start) begin
      period_hi <= cfg_period[31:16];
    end
  end

  // Running flag: set leaving the start write, cleared by stop or a one-shot timeout
  always_ff @(posedge clk) begin
    if (reset) begin
      running <= 1'b0;
    end else if (state == WR_START) begin
      running <= 1'b1;
    end else if (state == WR_STOP) begin
      running <= 1'b0;
    end else if (state == CLR_WAIT && !CONTINUOUS) begin
      running <= 1'b0;
    end
  end

  // Tick accounting: one pulse and one count per status-clear write
  always_ff @(posedge clk) begin
    if (reset) begin
      tick_pulse <= 1'b0;
      tick_count <= 32'd0;
    end else begin
      tick_pulse <= (state == WR_CLR);
      if (state == WR_CLR) begin
        tick_count <= tick_count + 32'd1;
      end
    end
  end

  // Snapshot assembly: low word arrives during RD_SNH, high word during CAP_H
  always_ff @(posedge clk) begin
    if (reset) begin
      snap_lo    <= 16'h0000;
      snap_valid <= 1'b0;
      snap_value <= 32'd0;
    end else begin
      snap_valid <= (state == CAP_H);
      if (state == RD_SNH) begin
        snap_lo <= tmr_readdata;
      end
      if (state == CAP_H) begin
        snap_value <= {tmr_readdata, snap_lo};
      end
    end
  end

endmodule
